// File: rtl/stream_demux_n.sv
// Registered 1-to-N stream demultiplexer with per-channel valid/ready,
// packet-locked routing and silent drop of out-of-range selects.
module stream_demux_n #(
    parameter int   N_OUT       = 4,
    parameter int   DATA_W      = 8,
    parameter bit   PACKET_MODE = 1'b1,
    localparam int  SEL_W       = $clog2(N_OUT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [DATA_W-1:0]         s_data,
    input  logic [SEL_W-1:0]          s_sel,
    input  logic                      s_last,
    output logic [N_OUT-1:0]          m_valid,
    input  logic [N_OUT-1:0]          m_ready,
    output logic [N_OUT*DATA_W-1:0]   m_data,
    output logic                      pkt_busy,
    output logic                      sel_err
);

    typedef enum logic [1:0] {IDLE, PKT, DROP} state_t;

    localparam bit SEL_CAN_BAD = (N_OUT != (1 << SEL_W));

    state_t              state;
    logic                hold_valid;
    logic [DATA_W-1:0]   hold_data;
    logic [SEL_W-1:0]    dest;

    logic sel_bad;
    logic drop_beat;
    logic dest_ready;
    logic accept;

    assign sel_bad = SEL_CAN_BAD && (32'(s_sel) >= N_OUT);

    // Beats that will be discarded bypass the holding register, so they never stall.
    assign drop_beat = (state == DROP) || ((state == IDLE) && sel_bad);
    assign s_ready   = drop_beat || !hold_valid || dest_ready;
    assign accept    = s_valid && s_ready;
    assign pkt_busy  = (state != IDLE);

    always_comb begin
        m_valid    = '0;
        m_data     = '0;
        dest_ready = 1'b0;
        for (int unsigned i = 0; i < N_OUT; i++) begin
            if (32'(dest) == i) begin
                m_valid[i]                  = hold_valid;
                m_data[i*DATA_W +: DATA_W]  = hold_data;
                dest_ready                  = m_ready[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            dest       <= '0;
            sel_err    <= 1'b0;
        end else begin
            sel_err <= accept && (state == IDLE) && sel_bad;

            // Inside a packet dest is left alone: it already holds the locked channel.
            if (accept && !drop_beat) begin
                hold_valid <= 1'b1;
                hold_data  <= s_data;
                if (state == IDLE)
                    dest <= s_sel;
            end else if (hold_valid && dest_ready) begin
                hold_valid <= 1'b0;
            end

            if (PACKET_MODE && accept) begin
                case (state)
                    IDLE:     if (!s_last) state <= sel_bad ? DROP : PKT;
                    PKT,
                    DROP:     if (s_last) state <= IDLE;
                    default:  state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_n.sv
// Bench for stream_demux_n: two instances (N_OUT=3 packet mode, N_OUT=4 beat mode)
// checked every cycle against a transaction-level model plus directed literal checks.
module tb_stream_demux_n;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Per-instance stimulus: index 0 = instance A (N_OUT=3, packet), 1 = instance B (N_OUT=4, beat)
    logic       sv [2];
    logic [7:0] sd [2];
    logic [1:0] ss [2];
    logic       sl [2];
    logic [3:0] mr [2];

    logic        a_s_ready, a_pkt_busy, a_sel_err;
    logic [2:0]  a_m_valid;
    logic [23:0] a_m_data;
    logic        b_s_ready, b_pkt_busy, b_sel_err;
    logic [3:0]  b_m_valid;
    logic [31:0] b_m_data;

    stream_demux_n #(.N_OUT(3), .DATA_W(8), .PACKET_MODE(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .s_valid(sv[0]), .s_ready(a_s_ready), .s_data(sd[0]), .s_sel(ss[0]), .s_last(sl[0]),
        .m_valid(a_m_valid), .m_ready(mr[0][2:0]), .m_data(a_m_data),
        .pkt_busy(a_pkt_busy), .sel_err(a_sel_err)
    );

    stream_demux_n #(.N_OUT(4), .DATA_W(8), .PACKET_MODE(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .s_valid(sv[1]), .s_ready(b_s_ready), .s_data(sd[1]), .s_sel(ss[1]), .s_last(sl[1]),
        .m_valid(b_m_valid), .m_ready(mr[1]), .m_data(b_m_data),
        .pkt_busy(b_pkt_busy), .sel_err(b_sel_err)
    );

    logic [3:0]  mv   [2];
    logic [31:0] md   [2];
    logic        rdy  [2];
    logic        busy [2];
    logic        serr [2];
    assign mv[0] = {1'b0, a_m_valid};  assign mv[1] = b_m_valid;
    assign md[0] = {8'h00, a_m_data};  assign md[1] = b_m_data;
    assign rdy[0] = a_s_ready;         assign rdy[1] = b_s_ready;
    assign busy[0] = a_pkt_busy;       assign busy[1] = b_pkt_busy;
    assign serr[0] = a_sel_err;        assign serr[1] = b_sel_err;

    int n_cmp = 0;
    int n_mis = 0;

    // Transaction-level model: one pending beat, last shown beat, packet mode 0/1(locked)/2(dropping)
    int unsigned nout [2] = '{3, 4};
    bit          pm   [2] = '{1'b1, 1'b0};
    bit          pend [2];
    int unsigned pdest[2];
    logic [7:0]  pdata[2];
    int unsigned mode [2];
    int unsigned lockc[2];
    bit          err  [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mreset(input int k);
        pend[k] = 1'b0; pdest[k] = 0; pdata[k] = 8'h00;
        mode[k] = 0; lockc[k] = 0; err[k] = 1'b0;
    endtask

    // Called just after a negedge with inputs already set; returns at the next negedge.
    task automatic cyc();
        bit bad, drop, rdy_e, acc, cons;
        string nm;
        #1;
        for (int k = 0; k < 2; k++) begin
            nm = (k == 0) ? "A" : "B";
            if (!rst_n) mreset(k);
            bad   = (int'(ss[k]) >= int'(nout[k]));
            drop  = (mode[k] == 2) || (mode[k] == 0 && bad);
            rdy_e = drop || !pend[k] || mr[k][pdest[k]];
            chk({nm, " s_ready"},  32'(rdy[k]),  32'(rdy_e));
            chk({nm, " m_valid"},  32'(mv[k]),   pend[k] ? (32'd1 << pdest[k]) : 32'd0);
            chk({nm, " m_data"},   md[k],        32'(pdata[k]) << (8 * pdest[k]));
            chk({nm, " pkt_busy"}, 32'(busy[k]), 32'(mode[k] != 0));
            chk({nm, " sel_err"},  32'(serr[k]), 32'(err[k]));
            acc  = rst_n && sv[k] && rdy_e;
            cons = rst_n && pend[k] && mr[k][pdest[k]];
            err[k] = acc && (mode[k] == 0) && bad;
            if (acc && !drop) begin
                pend[k]  = 1'b1;
                pdest[k] = (mode[k] == 1) ? lockc[k] : int'(ss[k]);
                pdata[k] = sd[k];
            end else if (cons) begin
                pend[k] = 1'b0;
            end
            if (pm[k] && acc) begin
                if (mode[k] == 0 && !sl[k]) begin
                    mode[k]  = bad ? 2 : 1;
                    lockc[k] = ss[k];
                end else if (mode[k] != 0 && sl[k]) begin
                    mode[k] = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic beat(input int k, input logic v, input logic [7:0] d, input logic [1:0] s,
                        input logic l, input logic [3:0] r);
        sv[k] = v; sd[k] = d; ss[k] = s; sl[k] = l; mr[k] = r;
    endtask

    logic [3:0] t2_v [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            beat(k, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
            mreset(k);
        end
        @(negedge clk);
        cyc();
        rst_n = 1'b1;
        cyc();

        // T1: async reset mid-cycle while a beat is held
        beat(0, 1'b1, 8'h3C, 2'd0, 1'b0, 4'b1110);
        cyc();
        beat(0, 1'b0, 8'h00, 2'd0, 1'b0, 4'b1110);
        chk("T1 pre m_valid", 32'(a_m_valid), 32'h1);
        chk("T1 pre busy", 32'(a_pkt_busy), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("T1 m_valid", 32'(a_m_valid), 32'h0);
        chk("T1 m_data", 32'(a_m_data), 32'h0);
        chk("T1 busy", 32'(a_pkt_busy), 32'h0);
        cyc();
        rst_n = 1'b1;
        beat(0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        #1 chk("T1 s_ready", 32'(a_s_ready), 32'h1);
        cyc();

        // T2: single beats to every channel of B, full throughput
        for (int i = 0; i < 4; i++) begin
            beat(1, 1'b1, 8'hA0 + 8'(i), 2'(i), 1'b0, 4'hF);
            cyc();
            chk("T2 m_valid", 32'(b_m_valid), 32'(t2_v[i]));
            chk("T2 m_data", b_m_data, 32'(8'hA0 + 8'(i)) << (8 * i));
        end

        // T3: backpressure on channel 2, then handshake with a new beat the same edge
        beat(1, 1'b1, 8'h5C, 2'd2, 1'b0, 4'b1011);
        cyc();
        for (int i = 0; i < 3; i++) begin
            beat(1, 1'b1, 8'h77, 2'd1, 1'b0, 4'b1011);
            #1;
            chk("T3 s_ready", 32'(b_s_ready), 32'h0);
            chk("T3 m_valid", 32'(b_m_valid), 32'h4);
            chk("T3 m_data", b_m_data, 32'h005C_0000);
            cyc();
        end
        beat(1, 1'b1, 8'h77, 2'd1, 1'b0, 4'hF);
        #1 chk("T3 release s_ready", 32'(b_s_ready), 32'h1);
        cyc();
        chk("T3 next m_valid", 32'(b_m_valid), 32'h2);
        chk("T3 next m_data", b_m_data, 32'h0000_7700);
        beat(1, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        cyc();

        // T4: packet locked to channel 1 while s_sel wanders
        beat(0, 1'b1, 8'h11, 2'd1, 1'b0, 4'hF); cyc();
        chk("T4 b0 m_valid", 32'(a_m_valid), 32'h2);
        chk("T4 b0 busy", 32'(a_pkt_busy), 32'h1);
        beat(0, 1'b1, 8'h22, 2'd3, 1'b0, 4'hF); cyc();
        chk("T4 b1 m_valid", 32'(a_m_valid), 32'h2);
        chk("T4 b1 m_data", 32'(a_m_data), 32'h2200);
        beat(0, 1'b1, 8'h33, 2'd0, 1'b1, 4'hF); cyc();
        chk("T4 b2 m_valid", 32'(a_m_valid), 32'h2);
        chk("T4 b2 busy", 32'(a_pkt_busy), 32'h0);
        beat(0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF); cyc();

        // T5: bad select on N_OUT=3 drops the whole packet with one sel_err pulse
        for (int i = 0; i < 4; i++) begin
            beat(0, 1'b1, 8'hE0 + 8'(i), 2'd3, (i == 3), 4'hF);
            #1 chk("T5 s_ready", 32'(a_s_ready), 32'h1);
            cyc();
            chk("T5 sel_err", 32'(a_sel_err), (i == 0) ? 32'h1 : 32'h0);
            chk("T5 m_valid", 32'(a_m_valid), 32'h0);
        end
        beat(0, 1'b1, 8'h5A, 2'd0, 1'b1, 4'hF); cyc();
        chk("T5 next m_valid", 32'(a_m_valid), 32'h1);
        chk("T5 next m_data", 32'(a_m_data), 32'h5A);
        beat(0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF); cyc();

        // T6: reset in the middle of a 4-beat packet
        beat(0, 1'b1, 8'h61, 2'd1, 1'b0, 4'hF); cyc();
        beat(0, 1'b1, 8'h62, 2'd0, 1'b0, 4'hF); cyc();
        beat(0, 1'b0, 8'h00, 2'd0, 1'b0, 4'hF);
        rst_n = 1'b0; cyc();
        rst_n = 1'b1;
        beat(0, 1'b1, 8'h63, 2'd2, 1'b0, 4'hF); cyc();
        chk("T6 m_valid", 32'(a_m_valid), 32'h4);
        chk("T6 busy", 32'(a_pkt_busy), 32'h1);
        beat(0, 1'b1, 8'h64, 2'd0, 1'b1, 4'hF); cyc();
        chk("T6 end m_valid", 32'(a_m_valid), 32'h4);
        chk("T6 end busy", 32'(a_pkt_busy), 32'h0);

        // Randomised traffic on both instances, with occasional resets
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 2; k++)
                beat(k, ($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom_range(0, 3)),
                     ($urandom_range(0, 3) == 0), 4'($urandom) | 4'($urandom));
            rst_n = ($urandom_range(0, 299) != 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
